// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//
// Multi-cycle instruction sequencer for a simple in-order core. It steps each
// instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB. It issues the
// instruction and data memory handshakes, the IR/RF/PC write strobes and the
// PC source select. A memory ack that does not arrive in time, or a system
// instruction, raises a one-cycle trap. The block then parks in HALT until
// reset.
//
// Parameters
//   TIMEOUT    max wait cycles for a memory ack (0 = wait forever)
//   TIMEOUT_W  width of the wait counter (TIMEOUT must fit)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_run                 start / continue enable
//   o_imem_req/i_imem_ack instruction fetch handshake
//   o_ir_we               instruction-register load strobe
//   i_is_*                decoder flags for the current IR
//   i_branch_taken        branch comparator result (valid in WB)
//   o_dmem_req/o_dmem_we/i_dmem_ack  data memory handshake
//   o_rf_we               register-file write strobe
//   o_pc_we/o_pc_sel      PC update (00 PC+4, 01 ALU target, 10 trap vector)
//   o_trap/o_trap_cause   trap pulse, cause (01 sys, 10 imem tmo, 11 dmem tmo)
//   o_halted/o_state/o_instret  halt flag, state code, retired count
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_run,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  output logic        o_ir_we,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic        i_is_writeback,
  input  logic        i_is_branch,
  input  logic        i_is_ja,
  input  logic        i_is_system,
  input  logic        i_branch_taken,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  output logic        o_rf_we,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause,
  output logic        o_halted,
  output logic [2:0]  o_state,
  output logic [31:0] o_instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Counter value seen on the last permitted wait cycle. When TIMEOUT is 0
  // the cast wraps, but the comparison is gated off below.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic [31:0]          r_instret;
  logic [1:0]           r_trap_cause;
  logic [1:0]           w_cause;
  logic                 w_timeout_hit;
  logic                 w_wait_entry;
  logic                 w_waiting;

  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST);

  // The counter restarts only on entry to a wait state, not on each
  // self-loop cycle spent waiting for an ack.
  assign w_wait_entry = ((w_next == S_FETCH) && (r_state != S_FETCH)) ||
                        ((w_next == S_MEM)   && (r_state != S_MEM));
  assign w_waiting    = ((r_state == S_FETCH) && !i_imem_ack) ||
                        ((r_state == S_MEM)   && !i_dmem_ack);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait counter, retired-instruction counter, trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt   <= '0;
      r_instret    <= 32'd0;
      r_trap_cause <= 2'b00;
    end else begin
      if (w_wait_entry) begin
        r_wait_cnt <= '0;
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      // Every WB cycle retires exactly one instruction; natural 32-bit wrap.
      if (r_state == S_WB) begin
        r_instret <= r_instret + 32'd1;
      end
      if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
        r_trap_cause <= w_cause;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next     = r_state;
    w_cause    = 2'b00;
    o_imem_req = 1'b0;
    o_ir_we    = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_sel   = 2'b00;
    o_trap     = 1'b0;
    o_halted   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) w_next = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req = 1'b1;
        // Ack is checked first so an ack on the timeout cycle wins.
        if (i_imem_ack) begin
          o_ir_we = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout_hit) begin
          w_next  = S_TRAP;
          w_cause = 2'b10;
        end
      end
      S_DECODE: begin
        if (i_is_system) begin
          w_next  = S_TRAP;
          w_cause = 2'b01;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = (i_is_load || i_is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = i_is_store;
        if (i_dmem_ack) begin
          w_next = S_WB;
        end else if (w_timeout_hit) begin
          w_next  = S_TRAP;
          w_cause = 2'b11;
        end
      end
      S_WB: begin
        o_rf_we  = i_is_writeback;
        o_pc_we  = 1'b1;
        o_pc_sel = (i_is_ja || (i_is_branch && i_branch_taken)) ? 2'b01 : 2'b00;
        // Run is only sampled at the instruction boundary.
        w_next   = i_run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        o_trap   = 1'b1;
        o_pc_we  = 1'b1;
        o_pc_sel = 2'b10;
        w_next   = S_HALT;
      end
      S_HALT: begin
        o_halted = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign o_state      = r_state;
  assign o_instret    = r_instret;
  assign o_trap_cause = r_trap_cause;

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
//
// Self-checking bench for core_sequencer (TIMEOUT = 4). Directed vectors
// come from a table of {inputs, expected outputs} records. Corner cases and
// randomized instruction streams are expanded by an instruction-level model
// into the same record format. Inputs change 1 ns after the rising edge.
// Outputs are compared 2 ns later, well away from either clock edge.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

  localparam int TMO = 4;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BR    = 3;
  localparam int K_JAL   = 4;
  localparam int K_NOP   = 5;
  localparam int K_SYS   = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        run, imem_ack, dmem_ack;
  logic        is_load, is_store, is_wb, is_branch, is_ja, is_system, branch_taken;
  logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap, halted;
  logic [1:0]  pc_sel, trap_cause;
  logic [2:0]  state;
  logic [31:0] instret;

  core_sequencer #(.TIMEOUT(TMO), .TIMEOUT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_run          (run),
    .o_imem_req     (imem_req),
    .i_imem_ack     (imem_ack),
    .o_ir_we        (ir_we),
    .i_is_load      (is_load),
    .i_is_store     (is_store),
    .i_is_writeback (is_wb),
    .i_is_branch    (is_branch),
    .i_is_ja        (is_ja),
    .i_is_system    (is_system),
    .i_branch_taken (branch_taken),
    .o_dmem_req     (dmem_req),
    .o_dmem_we      (dmem_we),
    .i_dmem_ack     (dmem_ack),
    .o_rf_we        (rf_we),
    .o_pc_we        (pc_we),
    .o_pc_sel       (pc_sel),
    .o_trap         (trap),
    .o_trap_cause   (trap_cause),
    .o_halted       (halted),
    .o_state        (state),
    .o_instret      (instret)
  );

  // in   = {run, imem_ack, dmem_ack, is_load, is_store, is_wb, is_branch, is_ja, is_system, branch_taken}
  // strb = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap}
  typedef struct {
    logic [9:0]  in;
    logic [2:0]  st;
    logic [6:0]  strb;
    logic [1:0]  sel;
    logic [1:0]  cause;
    logic        halt;
    logic [31:0] icnt;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  vec_t        q[$];
  logic [31:0] m_instret;
  logic [1:0]  m_cause;
  bit          m_idle;
  bit          m_halted;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [46:0] actual();
    return {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap,
            pc_sel, trap_cause, halted, instret};
  endfunction

  function automatic logic [46:0] exp_of(vec_t v);
    return {v.st, v.strb, v.sel, v.cause, v.halt, v.icnt};
  endfunction

  task automatic check(input string nm, input logic [46:0] act, input logic [46:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [9:0] in);
    {run, imem_ack, dmem_ack, is_load, is_store, is_wb, is_branch, is_ja,
     is_system, branch_taken} = in;
  endtask

  // Called 1 ns after a rising edge; returns 1 ns after the next one.
  task automatic apply(input vec_t v, input string nm);
    drive(v.in);
    #2;
    check(nm, actual(), exp_of(v));
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input string nm);
    foreach (q[i]) apply(q[i], $sformatf("%s[%0d]", nm, i));
    q.delete();
  endtask

  // Directed table entry: no trap history, not halted.
  function automatic vec_t tv(logic [9:0] in, logic [2:0] st, logic [6:0] strb,
                              logic [1:0] sel, logic [31:0] icnt);
    vec_t v;
    v.in = in; v.st = st; v.strb = strb; v.sel = sel;
    v.cause = 2'b00; v.halt = 1'b0; v.icnt = icnt;
    return v;
  endfunction

  // Model-generated entry: cause/instret from the current model state.
  function automatic vec_t mkv(logic [9:0] in, logic [2:0] st, logic [6:0] strb,
                               logic [1:0] sel);
    vec_t v;
    v.in = in; v.st = st; v.strb = strb; v.sel = sel;
    v.cause = m_cause; v.halt = (st == 3'd7); v.icnt = m_instret;
    return v;
  endfunction

  task automatic model_reset();
    m_instret = 32'd0;
    m_cause   = 2'b00;
    m_idle    = 1'b1;
    m_halted  = 1'b0;
  endtask

  // One TRAP cycle, then HALT for a few cycles while run/acks wander.
  task automatic add_trap(input logic [1:0] cause);
    m_cause = cause;
    q.push_back(mkv({rb(), rb(), rb(), 7'($urandom)}, 3'd6, 7'b0000011, 2'b10));
    for (int i = 0; i < 3; i++)
      q.push_back(mkv({rb(), rb(), rb(), 7'($urandom)}, 3'd7, 7'b0000000, 2'b00));
    m_halted = 1'b1;
  endtask

  task automatic add_idle();
    q.push_back(mkv({1'b0, rb(), rb(), 7'($urandom)}, 3'd0, 7'b0000000, 2'b00));
  endtask

  // Expand one instruction into per-cycle records. ilat/dlat give the cycle
  // (1-based) on which the ack arrives; a latency above TMO means no ack.
  task automatic add_instr(input int kind, input int ilat, input int dlat,
                           input bit taken, input bit run_end);
    logic       ld, st, wb, br, ja, sy, ack;
    logic [6:0] fl;
    if (m_halted) return;
    ld = (kind == K_LOAD);
    st = (kind == K_STORE);
    wb = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JAL);
    br = (kind == K_BR);
    ja = (kind == K_JAL);
    sy = (kind == K_SYS);
    fl = {ld, st, wb, br, ja, sy, taken};
    if (m_idle) begin
      q.push_back(mkv({1'b1, rb(), rb(), fl}, 3'd0, 7'b0000000, 2'b00));
      m_idle = 1'b0;
    end
    for (int c = 1; c <= TMO; c++) begin
      ack = (c == ilat);
      q.push_back(mkv({rb(), ack, rb(), fl}, 3'd1, {1'b1, ack, 5'b0}, 2'b00));
      if (ack) break;
    end
    if (ilat > TMO) begin add_trap(2'b10); return; end
    q.push_back(mkv({rb(), rb(), rb(), fl}, 3'd2, 7'b0000000, 2'b00));
    if (sy) begin add_trap(2'b01); return; end
    q.push_back(mkv({rb(), rb(), rb(), fl}, 3'd3, 7'b0000000, 2'b00));
    if (ld || st) begin
      for (int c = 1; c <= TMO; c++) begin
        ack = (c == dlat);
        q.push_back(mkv({rb(), rb(), ack, fl}, 3'd4, {2'b00, 1'b1, st, 3'b000}, 2'b00));
        if (ack) break;
      end
      if (dlat > TMO) begin add_trap(2'b11); return; end
    end
    q.push_back(mkv({run_end, rb(), rb(), fl}, 3'd5, {4'b0000, wb, 1'b1, 1'b0},
                    (ja || (br && taken)) ? 2'b01 : 2'b00));
    m_instret = m_instret + 32'd1;
    m_idle    = !run_end;
  endtask

  // Assert reset 1 ns after an edge, check outputs before any further edge,
  // release 1 ns after the following edge.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    drive(10'b0);
    #1;
    check(nm, actual(), 47'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    vec_t tbl[32];
    int   kind, ilat, dlat;
    bit   taken, run_end;

    // ---- reset state ----
    drive(10'b0);
    #3;
    check("reset_state", actual(), 47'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // ---- directed table: ALU, load, store, branches, jal, run drop ----
    tbl[0]  = tv(10'b1000010000, 3'd0, 7'b0000000, 2'b00, 32'd0);
    tbl[1]  = tv(10'b1000010000, 3'd1, 7'b1000000, 2'b00, 32'd0);
    tbl[2]  = tv(10'b1100010000, 3'd1, 7'b1100000, 2'b00, 32'd0);
    tbl[3]  = tv(10'b1000010000, 3'd2, 7'b0000000, 2'b00, 32'd0);
    tbl[4]  = tv(10'b1000010000, 3'd3, 7'b0000000, 2'b00, 32'd0);
    tbl[5]  = tv(10'b1000010000, 3'd5, 7'b0000110, 2'b00, 32'd0);
    tbl[6]  = tv(10'b1101010000, 3'd1, 7'b1100000, 2'b00, 32'd1);
    tbl[7]  = tv(10'b1001010000, 3'd2, 7'b0000000, 2'b00, 32'd1);
    tbl[8]  = tv(10'b1001010000, 3'd3, 7'b0000000, 2'b00, 32'd1);
    tbl[9]  = tv(10'b1101010000, 3'd4, 7'b0010000, 2'b00, 32'd1);
    tbl[10] = tv(10'b1001010000, 3'd4, 7'b0010000, 2'b00, 32'd1);
    tbl[11] = tv(10'b1011010000, 3'd4, 7'b0010000, 2'b00, 32'd1);
    tbl[12] = tv(10'b1001010000, 3'd5, 7'b0000110, 2'b00, 32'd1);
    tbl[13] = tv(10'b1110100000, 3'd1, 7'b1100000, 2'b00, 32'd2);
    tbl[14] = tv(10'b1000100000, 3'd2, 7'b0000000, 2'b00, 32'd2);
    tbl[15] = tv(10'b1000100000, 3'd3, 7'b0000000, 2'b00, 32'd2);
    tbl[16] = tv(10'b1010100000, 3'd4, 7'b0011000, 2'b00, 32'd2);
    tbl[17] = tv(10'b1000100000, 3'd5, 7'b0000010, 2'b00, 32'd2);
    tbl[18] = tv(10'b1100001001, 3'd1, 7'b1100000, 2'b00, 32'd3);
    tbl[19] = tv(10'b1000001001, 3'd2, 7'b0000000, 2'b00, 32'd3);
    tbl[20] = tv(10'b1000001001, 3'd3, 7'b0000000, 2'b00, 32'd3);
    tbl[21] = tv(10'b1000001001, 3'd5, 7'b0000010, 2'b01, 32'd3);
    tbl[22] = tv(10'b1100001000, 3'd1, 7'b1100000, 2'b00, 32'd4);
    tbl[23] = tv(10'b1000001000, 3'd2, 7'b0000000, 2'b00, 32'd4);
    tbl[24] = tv(10'b1000001000, 3'd3, 7'b0000000, 2'b00, 32'd4);
    tbl[25] = tv(10'b1000001000, 3'd5, 7'b0000010, 2'b00, 32'd4);
    tbl[26] = tv(10'b1100010100, 3'd1, 7'b1100000, 2'b00, 32'd5);
    tbl[27] = tv(10'b0000010100, 3'd2, 7'b0000000, 2'b00, 32'd5);
    tbl[28] = tv(10'b0000010100, 3'd3, 7'b0000000, 2'b00, 32'd5);
    tbl[29] = tv(10'b0000010100, 3'd5, 7'b0000110, 2'b01, 32'd5);
    tbl[30] = tv(10'b0000000000, 3'd0, 7'b0000000, 2'b00, 32'd6);
    tbl[31] = tv(10'b0110000000, 3'd0, 7'b0000000, 2'b00, 32'd6);
    for (int i = 0; i < 32; i++) apply(tbl[i], $sformatf("table[%0d]", i));
    $display("txn directed table: %0d vectors", 32);

    // ---- reset pulsed in the middle of a MEM cycle ----
    m_instret = 32'd6;
    m_cause   = 2'b00;
    m_idle    = 1'b1;
    m_halted  = 1'b0;
    add_instr(K_LOAD, 1, 3, 1'b0, 1'b1);
    while (q.size() > 0 && q[0].st != 3'd4) begin
      apply(q[0], "pre_mem");
      void'(q.pop_front());
    end
    if (q.size() > 0) begin
      drive(q[0].in);
      #2;
      check("in_mem", actual(), exp_of(q[0]));
    end
    q.delete();
    do_reset("rst_mid_mem");
    $display("txn reset during MEM");

    // ---- system instruction trap ----
    add_instr(K_SYS, 2, 0, 1'b0, 1'b1);
    flush("sys_trap");
    $display("txn system trap");

    // ---- dmem ack on the timeout cycle, then imem timeout ----
    do_reset("rst_b");
    add_instr(K_LOAD, 1, TMO, 1'b0, 1'b1);
    add_instr(K_ALU, TMO + 1, 0, 1'b0, 1'b1);
    flush("tmo_imem");
    $display("txn dmem ack at timeout, imem timeout trap");

    // ---- dmem timeout ----
    do_reset("rst_c");
    add_instr(K_STORE, 1, TMO + 1, 1'b0, 1'b1);
    flush("tmo_dmem");
    $display("txn dmem timeout trap");

    // ---- instret wrap ----
    do_reset("rst_d");
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    m_instret = 32'hFFFF_FFFF;
    add_instr(K_ALU, 1, 0, 1'b0, 1'b1);
    add_instr(K_NOP, 2, 0, 1'b0, 1'b0);
    add_idle();
    flush("wrap");
    $display("txn instret wrap");

    // ---- randomized instruction streams ----
    for (int r = 0; r < 8; r++) begin
      do_reset($sformatf("rst_rnd%0d", r));
      for (int k = 0; k < 10 && !m_halted; k++) begin
        kind    = ($urandom_range(0, 15) == 0) ? K_SYS : int'($urandom_range(0, 5));
        ilat    = ($urandom_range(0, 11) == 0) ? TMO + 1 : int'($urandom_range(1, TMO));
        dlat    = ($urandom_range(0, 11) == 0) ? TMO + 1 : int'($urandom_range(1, TMO));
        taken   = rb();
        run_end = ($urandom_range(0, 3) != 0);
        $display("txn rnd%0d.%0d kind=%0d ilat=%0d dlat=%0d taken=%0d run_end=%0d",
                 r, k, kind, ilat, dlat, taken, run_end);
        add_instr(kind, ilat, dlat, taken, run_end);
        flush($sformatf("rnd%0d.%0d", r, k));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255: max wait cycles for a memory ack; 0 disables the timeout.
REQ-002 Parameter TIMEOUT_W, default 8: width of the wait counter; TIMEOUT SHALL fit in TIMEOUT_W bits.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 run  in  1  start/continue enable.
REQ-006 imem_req  out  1 / imem_ack  in  1  instruction fetch handshake.
REQ-007 ir_we  out  1  instruction-register load strobe.
REQ-008 is_load, is_store, is_writeback, is_branch, is_ja, is_system  in  1 each  decoder flags for the current IR.
REQ-009 branch_taken  in  1  branch comparator result, valid in WB.
REQ-010 dmem_req  out  1 / dmem_we  out  1 / dmem_ack  in  1  data memory handshake.
REQ-011 rf_we  out  1  register-file write strobe.
REQ-012 pc_we  out  1 / pc_sel  out  2  PC update strobe; 00 = PC+4, 01 = ALU target, 10 = trap vector.
REQ-013 trap  out  1  one-cycle trap pulse; trap_cause  out  2  01 system, 10 imem timeout, 11 dmem timeout.
REQ-014 halted  out  1 / state  out  3 / instret  out  32  halt flag, current state code, retired-instruction count.

Function
REQ-015 States SHALL be encoded IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6, HALT=7, and the code SHALL appear on state.
REQ-016 IDLE: all strobes 0; go to FETCH on the first edge with run=1.
REQ-017 FETCH: imem_req=1 combinationally for every FETCH cycle; when imem_ack=1, ir_we=1 in that same cycle and the next state SHALL be DECODE.
REQ-018 DECODE: one cycle; is_system=1 -> TRAP with cause 01; otherwise -> EXEC.
REQ-019 EXEC: one cycle; (is_load|is_store)=1 -> MEM; otherwise -> WB.
REQ-020 MEM: dmem_req=1 and dmem_we=is_store for every MEM cycle; dmem_ack=1 -> WB.
REQ-021 WB: one cycle; rf_we=is_writeback, pc_we=1, pc_sel=01 if is_ja|(is_branch&branch_taken), else 00; instret increments by 1.
REQ-022 WB next state SHALL be FETCH if run=1, else IDLE; deasserting run SHALL never abort an instruction in progress.
REQ-023 Wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without ack.
REQ-024 If TIMEOUT!=0 and the counter equals TIMEOUT-1 with ack=0, next state SHALL be TRAP with cause 10 (FETCH) or 11 (MEM).
REQ-025 Ack and timeout in the same cycle: ack wins and no trap is raised.
REQ-026 TRAP: one cycle; trap=1, pc_we=1, pc_sel=10; next state HALT.
REQ-027 trap_cause SHALL be captured on entry to TRAP and held until reset.
REQ-028 HALT: halted=1 and all strobes 0; the block remains in HALT regardless of run or ack until reset.
REQ-029 instret SHALL wrap from 0xFFFFFFFF to 0 without side effects.
REQ-030 Acks arriving outside FETCH (imem) or MEM (dmem) SHALL be ignored.
REQ-031 ir_we, rf_we, pc_we, dmem_we and trap SHALL never be asserted outside the states defined above.

Reset
REQ-032 rst_n=0 SHALL force state=IDLE, instret=0, trap_cause=00, wait counter=0 and all outputs 0 immediately, independent of clk.
REQ-033 Reset asserted in FETCH or MEM SHALL drop imem_req/dmem_req in the same cycle; after release the block SHALL start from IDLE.

Verification
REQ-034 ALU op (is_writeback=1), run=1, imem_ack on the 2nd FETCH cycle -> state sequence 1,1,2,3,5,1; rf_we=1 and pc_sel=00 in WB; instret=1.
REQ-035 Load with dmem_ack after 3 MEM cycles -> MEM lasts 3 cycles with dmem_we=0; WB has rf_we=1; then a store -> dmem_we=1 in MEM and rf_we=0 in WB.
REQ-036 Branch with branch_taken=1 -> pc_sel=01 in WB; same branch with branch_taken=0 -> pc_sel=00; jal (is_ja=1) -> pc_sel=01 and rf_we=1.
REQ-037 TIMEOUT=4 with imem_ack held 0 -> TRAP after 4 FETCH cycles with trap=1 for one cycle, pc_sel=10, trap_cause=10; then halted=1 while run toggles.
REQ-038 is_system=1 at DECODE -> TRAP with cause 01; also cover dmem_ack arriving exactly on the timeout cycle -> WB, no trap.
REQ-039 rst_n pulsed low mid-MEM -> outputs 0 asynchronously, instret=0; also preload instret near 0xFFFFFFFF and retire 2 instructions -> instret wraps to 0 then 1.
